dps_lsflags_mc: RTL and testbench

- Multi-channel, parametrised load/store-flags capture register in the dps block.
- Accumulates per-channel event flags (e.g. SCI TX/RX interrupt-enable reports plus future peripherals) into one 32-bit status word.
- The status word is returned on a registered read port with 1-cycle latency and optional clear-on-read.
- Also provides a mask, an overflow indicator and a level interrupt output.

---
 rtl/dps_lsflags_pkg.sv | 20 ++
 rtl/dps_lsflags_ch.sv | 78 +++++++
 rtl/dps_lsflags_mc.sv | 104 ++++++++++
 tb/tb_dps_lsflags_mc.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/dps_lsflags_pkg.sv
// ============================================================================
// Module : dps_lsflags_pkg
// Brief  : Shared constants and helpers for the dps load/store-flags capture.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dps_lsflags_pkg;

    localparam int LSFLAGS_W = 32;
    localparam int OVF_BIT   = 31;

    // Bit offset of a channel's field inside the packed flag vector.
    function automatic int ch_offset(input int ch, input int fw);
        return ch * fw;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dps_lsflags_ch.sv
// ============================================================================
// Module : dps_lsflags_ch
// Brief  : One channel's flag field with mask, sticky/overwrite merge, clear
//          and overflow detection.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dps_lsflags_ch #(
    parameter int FW     = 2,
    parameter int STICKY = 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_rst_sync,
    input  logic          i_evt_valid,
    input  logic [FW-1:0] i_evt_flags,
    input  logic          i_mask_wr,
    input  logic [FW-1:0] i_mask_data,
    input  logic          i_clr,
    output logic [FW-1:0] o_flags,
    output logic [FW-1:0] o_flags_nxt,
    output logic          o_ovf
);

    localparam bit c_STICKY = (STICKY != 0);

    logic [FW-1:0] r_flags;
    logic [FW-1:0] r_mask;
    logic          r_ovf;

    logic [FW-1:0] w_evt;
    logic [FW-1:0] w_base;
    logic [FW-1:0] w_nxt;
    logic          w_hit;

    // Events are always filtered by the mask in force before any mask write.
    assign w_evt  = {FW{i_evt_valid}} & i_evt_flags & r_mask;
    assign w_base = i_clr ? '0 : r_flags;

    // Overwrite mode replaces the field by design, so only sticky mode can
    // lose information by hitting an already-set bit.
    always_comb begin
        w_nxt = w_base;
        w_hit = 1'b0;
        if (c_STICKY) begin
            w_nxt = w_base | w_evt;
            w_hit = (|(w_evt & r_flags)) & ~i_clr;
        end else if (i_evt_valid) begin
            w_nxt = w_evt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_flags <= '0;
            r_mask  <= '1;
            r_ovf   <= 1'b0;
        end else if (i_rst_sync) begin
            r_flags <= '0;
            r_mask  <= '1;
            r_ovf   <= 1'b0;
        end else begin
            r_flags <= w_nxt;
            r_ovf   <= (r_ovf & ~i_clr) | w_hit;
            if (i_mask_wr) begin
                r_mask <= i_mask_data;
            end
        end
    end

    assign o_flags     = r_flags;
    assign o_flags_nxt = w_nxt;
    assign o_ovf       = r_ovf;

endmodule

`default_nettype wire

// File: rtl/dps_lsflags_mc.sv
// ============================================================================
// Module : dps_lsflags_mc
// Brief  : Multi-channel load/store-flags capture register with masked
//          event accumulation, registered read port, overflow and IRQ.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dps_lsflags_mc
    import dps_lsflags_pkg::*;
#(
    parameter int P_CH            = 2,
    parameter int P_FW            = 2,
    parameter int P_STICKY        = 1,
    parameter int P_CLEAR_ON_READ = 1
) (
    input  logic                 iCLOCK,
    input  logic                 inRESET,
    input  logic                 iRESET_SYNC,
    input  logic [P_CH-1:0]      iEVT_VALID,
    input  logic [P_CH*P_FW-1:0] iEVT_FLAGS,
    input  logic                 iMASK_WR,
    input  logic [P_CH*P_FW-1:0] iMASK_DATA,
    input  logic                 iCLEAR,
    input  logic                 iREAD_VALID,
    output logic                 oLSFLAGS_VALID,
    output logic [LSFLAGS_W-1:0] oLSFLAGS,
    output logic                 oIRQ
);

    localparam int c_NB  = P_CH * P_FW;
    localparam bit c_COR = (P_CLEAR_ON_READ != 0);

    generate
        if (c_NB > OVF_BIT || P_CH < 1 || P_CH > 15) begin : g_bad_cfg
            $error("dps_lsflags_mc: illegal P_CH/P_FW combination");
        end
    endgenerate

    logic [c_NB-1:0]      w_flags;
    logic [c_NB-1:0]      w_flags_nxt;
    logic [P_CH-1:0]      w_ovf_ch;
    logic                 w_clr;
    logic [LSFLAGS_W-1:0] w_word;

    logic                 r_rvalid;
    logic [LSFLAGS_W-1:0] r_rdata;
    logic                 r_irq;

    assign w_clr = iCLEAR | (iREAD_VALID & c_COR);

    generate
        for (genvar gi = 0; gi < P_CH; gi++) begin : g_ch
            dps_lsflags_ch #(
                .FW     (P_FW),
                .STICKY (P_STICKY)
            ) u_ch (
                .i_clk       (iCLOCK),
                .i_rst_n     (inRESET),
                .i_rst_sync  (iRESET_SYNC),
                .i_evt_valid (iEVT_VALID[gi]),
                .i_evt_flags (iEVT_FLAGS[ch_offset(gi, P_FW) +: P_FW]),
                .i_mask_wr   (iMASK_WR),
                .i_mask_data (iMASK_DATA[ch_offset(gi, P_FW) +: P_FW]),
                .i_clr       (w_clr),
                .o_flags     (w_flags[ch_offset(gi, P_FW) +: P_FW]),
                .o_flags_nxt (w_flags_nxt[ch_offset(gi, P_FW) +: P_FW]),
                .o_ovf       (w_ovf_ch[gi])
            );
        end
    endgenerate

    // Read data is the pre-update state, so same-cycle events never appear.
    always_comb begin
        w_word             = '0;
        w_word[c_NB-1:0]   = w_flags;
        w_word[OVF_BIT]    = |w_ovf_ch;
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_irq    <= 1'b0;
        end else if (iRESET_SYNC) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_irq    <= 1'b0;
        end else begin
            r_rvalid <= iREAD_VALID;
            if (iREAD_VALID) begin
                r_rdata <= w_word;
            end
            r_irq <= |w_flags_nxt;
        end
    end

    assign oLSFLAGS_VALID = r_rvalid;
    assign oLSFLAGS       = r_rdata;
    assign oIRQ           = r_irq;

endmodule

`default_nettype wire

// File: tb/tb_dps_lsflags_mc.sv
// ============================================================================
// Module : tb_dps_lsflags_mc
// Brief  : Self-checking bench: sticky/clear-on-read and overwrite/no-clear
//          instances against an integer reference model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dps_lsflags_mc;

    localparam int CH = 2;
    localparam int FW = 2;
    localparam int NB = CH * FW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rst_sync;
    logic [CH-1:0] evt_valid;
    logic [NB-1:0] evt_flags;
    logic          mask_wr;
    logic [NB-1:0] mask_data;
    logic          clear;
    logic          rd;

    logic          vld_a, irq_a, vld_b, irq_b;
    logic [31:0]   rd_a, rd_b;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state per instance: 0 = sticky + clear-on-read, 1 = overwrite.
    int unsigned mf[2], mo[2], mm[2], mrd[2];
    bit          mrv[2], mirq[2];

    always #5 clk = ~clk;

    dps_lsflags_mc #(.P_CH(CH), .P_FW(FW), .P_STICKY(1), .P_CLEAR_ON_READ(1)) u_dut_a (
        .iCLOCK(clk), .inRESET(rst_n), .iRESET_SYNC(rst_sync),
        .iEVT_VALID(evt_valid), .iEVT_FLAGS(evt_flags),
        .iMASK_WR(mask_wr), .iMASK_DATA(mask_data), .iCLEAR(clear),
        .iREAD_VALID(rd), .oLSFLAGS_VALID(vld_a), .oLSFLAGS(rd_a), .oIRQ(irq_a)
    );

    dps_lsflags_mc #(.P_CH(CH), .P_FW(FW), .P_STICKY(0), .P_CLEAR_ON_READ(0)) u_dut_b (
        .iCLOCK(clk), .inRESET(rst_n), .iRESET_SYNC(rst_sync),
        .iEVT_VALID(evt_valid), .iEVT_FLAGS(evt_flags),
        .iMASK_WR(mask_wr), .iMASK_DATA(mask_data), .iCLEAR(clear),
        .iREAD_VALID(rd), .oLSFLAGS_VALID(vld_b), .oLSFLAGS(rd_b), .oIRQ(irq_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%08h expected=%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            mf[m] = 0; mo[m] = 0; mm[m] = (1 << NB) - 1;
            mrd[m] = 0; mrv[m] = 0; mirq[m] = 0;
        end
    endtask

    task automatic model_step(input int m, input bit sticky, input bit cor);
        int unsigned nf, fm, e;
        bit          clr, hit;
        if (rst_sync) begin
            mf[m] = 0; mo[m] = 0; mm[m] = (1 << NB) - 1;
            mrd[m] = 0; mrv[m] = 0; mirq[m] = 0;
            return;
        end
        clr    = clear | (rd & cor);
        mrv[m] = rd;
        if (rd) mrd[m] = (mo[m] << 31) | mf[m];
        nf  = clr ? 0 : mf[m];
        hit = 0;
        for (int c = 0; c < CH; c++) begin
            fm = ((1 << FW) - 1) << (c * FW);
            if (evt_valid[c]) begin
                e = int'(evt_flags) & mm[m] & fm;
                if (sticky) begin
                    if (!clr && ((e & mf[m]) != 0)) hit = 1;
                    nf = nf | e;
                end else begin
                    nf = (nf & ~fm) | e;
                end
            end
        end
        mo[m]   = (clr ? 0 : mo[m]) | 32'(hit);
        mf[m]   = nf;
        mirq[m] = (nf != 0);
        if (mask_wr) mm[m] = int'(mask_data);
    endtask

    task automatic compare_all();
        chk("a_valid", 32'(vld_a), 32'(mrv[0]));
        chk("a_data",  rd_a,       mrd[0]);
        chk("a_irq",   32'(irq_a), 32'(mirq[0]));
        chk("b_valid", 32'(vld_b), 32'(mrv[1]));
        chk("b_data",  rd_b,       mrd[1]);
        chk("b_irq",   32'(irq_b), 32'(mirq[1]));
    endtask

    task automatic cyc();
        @(posedge clk);
        if (rst_n) begin
            model_step(0, 1'b1, 1'b1);
            model_step(1, 1'b0, 1'b0);
        end
        @(negedge clk);
        compare_all();
    endtask

    task automatic drv(input logic [CH-1:0] v, input logic [NB-1:0] f, input logic mw,
                       input logic [NB-1:0] md, input logic c, input logic r);
        evt_valid = v; evt_flags = f; mask_wr = mw; mask_data = md; clear = c; rd = r;
        rst_sync = 1'b0;
        cyc();
    endtask

    task automatic idle();
        drv('0, '0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; rst_sync = 1'b0; evt_valid = '0; evt_flags = '0;
        mask_wr = 1'b0; mask_data = '0; clear = 1'b0; rd = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        rst_n = 1'b1;

        // Read straight after reset returns zero.
        drv('0, '0, 0, '0, 0, 1);
        chk("rst_read_a", rd_a, 32'h0);
        idle();

        // Two channels, then a read, then a read of the cleared word.
        drv(2'b01, 4'b0001, 0, '0, 0, 0);
        drv(2'b10, 4'b1000, 0, '0, 0, 0);
        drv('0, '0, 0, '0, 0, 1);
        chk("two_ch_a", rd_a, 32'h9);
        drv('0, '0, 0, '0, 0, 1);
        chk("cleared_a", rd_a, 32'h0);

        // Event in the same cycle as a clearing read is retained.
        drv(2'b01, 4'b0001, 0, '0, 0, 0);
        drv(2'b01, 4'b0011, 0, '0, 0, 1);
        chk("same_cyc_a", rd_a, 32'h1);
        drv('0, '0, 0, '0, 0, 1);
        chk("retained_a", rd_a, 32'h3);

        // Repeated event on a set bit raises overflow.
        drv(2'b01, 4'b0001, 0, '0, 0, 0);
        drv(2'b01, 4'b0001, 0, '0, 0, 0);
        drv('0, '0, 0, '0, 0, 1);
        chk("ovf_a", rd_a, 32'h8000_0001);
        drv('0, '0, 0, '0, 0, 1);
        chk("ovf_clr_a", rd_a, 32'h0);

        // Mask write, then a partially masked event.
        drv('0, '0, 1, 4'b1110, 0, 0);
        drv(2'b01, 4'b0011, 0, '0, 0, 0);
        chk("mask_irq_a", 32'(irq_a), 32'h1);
        drv('0, '0, 0, '0, 0, 1);
        chk("mask_a", rd_a, 32'h2);
        drv('0, '0, 1, 4'b1111, 1, 0);

        // Overwrite, non-destructive reads on instance B.
        drv(2'b10, 4'b1100, 0, '0, 0, 0);
        drv(2'b10, 4'b0100, 0, '0, 0, 0);
        drv('0, '0, 0, '0, 0, 1);
        chk("ovw_rd1_b", rd_b, 32'h4);
        drv('0, '0, 0, '0, 0, 1);
        chk("ovw_rd2_b", rd_b, 32'h4);
        drv('0, '0, 0, '0, 1, 0);
        drv('0, '0, 0, '0, 0, 1);
        chk("clear_b", rd_b, 32'h0);

        // Synchronous reset wins over a simultaneous event and read.
        drv(2'b11, 4'b1111, 0, '0, 0, 0);
        evt_valid = 2'b11; evt_flags = 4'b1111; rd = 1'b1; rst_sync = 1'b1;
        cyc();
        chk("srst_irq_a", 32'(irq_a), 32'h0);
        chk("srst_vld_b", 32'(vld_b), 32'h0);
        idle();

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            evt_valid = CH'($urandom);
            evt_flags = NB'($urandom);
            mask_wr   = ($urandom_range(0, 7) == 0);
            mask_data = NB'($urandom);
            clear     = ($urandom_range(0, 7) == 0);
            rd        = ($urandom_range(0, 2) == 0);
            rst_sync  = ($urandom_range(0, 63) == 0);
            cyc();
        end

        // Asynchronous reset with a read pending: no response afterwards.
        drv(2'b11, 4'b1111, 0, '0, 0, 0);
        rd = 1'b1; evt_valid = '0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        rd = 1'b0; rst_n = 1'b1;
        idle();
        chk("arst_novld_a", 32'(vld_a), 32'h0);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
